// File: rtl/dw_weight_cache_pp.sv
// Ping-pong depthwise weight cache: the loader fills one bank while the other
// bank streams its K*K taps, REPEAT times, to the MAC array.
module dw_weight_cache_pp #(
  parameter int UNIT_NUM = 16,
  parameter int DATA_W   = 8,
  parameter int K        = 3,
  parameter int IDX_W    = 4,
  parameter int ADDR_W   = 19,
  parameter int CNT_W    = 18,
  localparam int LANE_W  = UNIT_NUM * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              load_done,
  output logic              load_err,
  output logic              ldr_req,
  input  logic              ldr_grant,
  output logic [ADDR_W-1:0] ldr_base_addr,
  output logic [CNT_W-1:0]  ldr_count,
  input  logic              ldr_valid,
  input  logic [LANE_W-1:0] ldr_data,
  input  logic              ldr_done_sig,
  input  logic              stream_start,
  input  logic [15:0]       repeat_num,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [IDX_W-1:0]  w_idx,
  output logic [LANE_W-1:0] w_data,
  output logic              w_last,
  output logic [1:0]        bank_vld
);

  localparam int KK   = K * K;
  localparam int CW   = $clog2(KK + 1);
  localparam int MA_W = $clog2(KK);
  localparam logic [CW-1:0] KK_C  = CW'(KK);
  localparam logic [CW-1:0] KK1_C = CW'(KK - 1);

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_REQ  = 2'd1;
  localparam logic [1:0] L_RECV = 2'd2;
  localparam logic       S_IDLE = 1'b0;
  localparam logic       S_RUN  = 1'b1;

  logic [1:0]        l_state_q, l_state_d;
  logic              s_state_q, s_state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        bank_vld_q, bank_vld_d;
  logic [CW-1:0]     recv_cnt_q, recv_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [15:0]       rep_left_q, rep_left_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic [LANE_W-1:0] mem_q [2][KK];

  logic          mem_we;
  logic          set_vld;
  logic          clr_vld;
  logic [CW-1:0] recv_inc;
  logic [CW-1:0] recv_fin;

  // Beat counter saturates so an over-long transfer still reads as != KK.
  assign recv_inc = (&recv_cnt_q) ? recv_cnt_q : recv_cnt_q + CW'(1);
  assign recv_fin = ldr_valid ? recv_inc : recv_cnt_q;

  always_comb begin
    l_state_d   = l_state_q;
    recv_cnt_d  = recv_cnt_q;
    base_d      = base_q;
    wr_bank_d   = wr_bank_q;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    set_vld     = 1'b0;
    mem_we      = 1'b0;
    case (l_state_q)
      L_IDLE: begin
        if (load_start && !bank_vld_q[wr_bank_q]) begin
          base_d     = base_addr;
          recv_cnt_d = '0;
          l_state_d  = L_REQ;
        end
      end
      L_REQ: begin
        if (ldr_grant) l_state_d = L_RECV;
      end
      L_RECV: begin
        if (ldr_valid) begin
          recv_cnt_d = recv_inc;
          mem_we     = (recv_cnt_q < KK_C);
        end
        if (ldr_done_sig) begin
          l_state_d = L_IDLE;
          if (recv_fin == KK_C) begin
            load_done_d = 1'b1;
            set_vld     = 1'b1;
            wr_bank_d   = ~wr_bank_q;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      default: l_state_d = L_IDLE;
    endcase
    if (flush) begin
      l_state_d   = L_IDLE;
      wr_bank_d   = 1'b0;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      set_vld     = 1'b0;
      mem_we      = 1'b0;
    end
  end

  always_comb begin
    s_state_d  = s_state_q;
    out_cnt_d  = out_cnt_q;
    rep_left_d = rep_left_q;
    rd_bank_d  = rd_bank_q;
    clr_vld    = 1'b0;
    case (s_state_q)
      S_IDLE: begin
        if (stream_start && bank_vld_q[rd_bank_q]) begin
          s_state_d  = S_RUN;
          out_cnt_d  = '0;
          rep_left_d = (repeat_num == 16'd0) ? 16'd0 : repeat_num - 16'd1;
        end
      end
      default: begin
        if (w_ready) begin
          if (out_cnt_q == KK1_C) begin
            out_cnt_d = '0;
            if (rep_left_q == 16'd0) begin
              s_state_d = S_IDLE;
              clr_vld   = 1'b1;
              rd_bank_d = ~rd_bank_q;
            end else begin
              rep_left_d = rep_left_q - 16'd1;
            end
          end else begin
            out_cnt_d = out_cnt_q + CW'(1);
          end
        end
      end
    endcase
    if (flush) begin
      s_state_d = S_IDLE;
      rd_bank_d = 1'b0;
      clr_vld   = 1'b0;
    end
  end

  // Load and stream never target the same bank, so clear and set cannot collide.
  always_comb begin
    bank_vld_d = bank_vld_q;
    if (clr_vld) bank_vld_d[rd_bank_q] = 1'b0;
    if (set_vld) bank_vld_d[wr_bank_q] = 1'b1;
    if (flush)   bank_vld_d = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_state_q   <= L_IDLE;
      s_state_q   <= S_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_vld_q  <= 2'b00;
      recv_cnt_q  <= '0;
      out_cnt_q   <= '0;
      rep_left_q  <= '0;
      base_q      <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      l_state_q   <= l_state_d;
      s_state_q   <= s_state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_vld_q  <= bank_vld_d;
      recv_cnt_q  <= recv_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rep_left_q  <= rep_left_d;
      base_q      <= base_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_bank_q][recv_cnt_q[MA_W-1:0]] <= ldr_data;
  end

  assign ldr_req       = (l_state_q == L_REQ);
  assign ldr_base_addr = base_q;
  assign ldr_count     = CNT_W'(KK);
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign w_valid       = (s_state_q == S_RUN);
  assign w_idx         = IDX_W'(out_cnt_q);
  assign w_data        = w_valid ? mem_q[rd_bank_q][out_cnt_q[MA_W-1:0]] : '0;
  assign w_last        = w_valid && (out_cnt_q == KK1_C) && (rep_left_q == 16'd0);
  assign bank_vld      = bank_vld_q;

endmodule

// File: tb/tb_dw_weight_cache_pp.sv
// Directed bench for dw_weight_cache_pp: load, stream, overlap, backpressure,
// ignored requests, bad beat counts, flush and asynchronous reset.
module tb_dw_weight_cache_pp;

  localparam int KK     = 9;
  localparam int LANE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              load_start;
  logic [18:0]       base_addr;
  logic              load_done;
  logic              load_err;
  logic              ldr_req;
  logic              ldr_grant;
  logic [18:0]       ldr_base_addr;
  logic [17:0]       ldr_count;
  logic              ldr_valid;
  logic [LANE_W-1:0] ldr_data;
  logic              ldr_done_sig;
  logic              stream_start;
  logic [15:0]       repeat_num;
  logic              w_valid;
  logic              w_ready;
  logic [3:0]        w_idx;
  logic [LANE_W-1:0] w_data;
  logic              w_last;
  logic [1:0]        bank_vld;

  int total = 0;
  int bad   = 0;

  dw_weight_cache_pp dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .load_start(load_start), .base_addr(base_addr),
    .load_done(load_done), .load_err(load_err),
    .ldr_req(ldr_req), .ldr_grant(ldr_grant),
    .ldr_base_addr(ldr_base_addr), .ldr_count(ldr_count),
    .ldr_valid(ldr_valid), .ldr_data(ldr_data), .ldr_done_sig(ldr_done_sig),
    .stream_start(stream_start), .repeat_num(repeat_num),
    .w_valid(w_valid), .w_ready(w_ready), .w_idx(w_idx),
    .w_data(w_data), .w_last(w_last), .bank_vld(bank_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [LANE_W-1:0] obs,
                       input logic [LANE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every lane of every tap carries a distinct byte.
  function automatic logic [LANE_W-1:0] dval(input int b, input int i);
    logic [LANE_W-1:0] v;
    for (int j = 0; j < 16; j++) v[j*8 +: 8] = 8'(b + i * 16 + j);
    return v;
  endfunction

  task automatic do_load(input int addr, input int dbase, input int nbeats,
                         input int gdly, input bit same_cycle);
    @(negedge clk);
    load_start = 1'b1;
    base_addr  = 19'(addr);
    @(negedge clk);
    load_start = 1'b0;
    for (int g = 0; g < gdly; g++) begin
      check("ldr_req_wait", ldr_req, 1);
      @(negedge clk);
    end
    check("ldr_req_hi", ldr_req, 1);
    check("ldr_base_addr", ldr_base_addr, addr);
    check("ldr_count", ldr_count, KK);
    ldr_grant = 1'b1;
    @(negedge clk);
    ldr_grant = 1'b0;
    check("ldr_req_lo", ldr_req, 0);
    for (int i = 0; i < nbeats; i++) begin
      ldr_valid = 1'b1;
      ldr_data  = dval(dbase, i);
      if (same_cycle && i == nbeats - 1) ldr_done_sig = 1'b1;
      @(negedge clk);
    end
    if (!same_cycle) begin
      ldr_valid    = 1'b0;
      ldr_done_sig = 1'b1;
      @(negedge clk);
    end
    ldr_valid    = 1'b0;
    ldr_done_sig = 1'b0;
    check("load_done_pulse", load_done, nbeats == KK);
    check("load_err_pulse", load_err, nbeats != KK);
    @(negedge clk);
    check("load_done_end", load_done, 0);
    check("load_err_end", load_err, 0);
  endtask

  task automatic stream(input int dbase, input int reps, input bit bp,
                        input int flush_at);
    int n_exp;
    int got;
    int budget;
    n_exp  = KK * ((reps == 0) ? 1 : reps);
    got    = 0;
    budget = 0;
    @(negedge clk);
    stream_start = 1'b1;
    repeat_num   = 16'(reps);
    w_ready      = 1'b0;
    @(negedge clk);
    stream_start = 1'b0;
    while (got < n_exp && budget < 2000) begin
      if (flush_at >= 0 && got == flush_at) begin
        w_ready = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_w_valid", w_valid, 0);
        check("flush_ldr_req", ldr_req, 0);
        check("flush_bank_vld", bank_vld, 2'b00);
        return;
      end
      w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      check("w_valid", w_valid, 1);
      check("w_idx", w_idx, got % KK);
      check("w_data", w_data, dval(dbase, got % KK));
      check("w_last", w_last, got == n_exp - 1);
      if (w_ready) got++;
      budget++;
      @(negedge clk);
    end
    w_ready = 1'b0;
    check("stream_beats", got, n_exp);
    check("w_valid_end", w_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; load_start = 1'b0; base_addr = '0;
    ldr_grant = 1'b0; ldr_valid = 1'b0; ldr_data = '0; ldr_done_sig = 1'b0;
    stream_start = 1'b0; repeat_num = '0; w_ready = 1'b0;
    #23;
    check("rst_w_valid", w_valid, 0);
    check("rst_ldr_req", ldr_req, 0);
    check("rst_bank_vld", bank_vld, 0);
    check("rst_load_done", load_done, 0);
    check("rst_w_data", w_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single load into bank0 then a single stream.
    do_load(32'h100, 8'h10, KK, 2, 1'b0);
    check("s1_bank_vld", bank_vld, 2'b01);
    stream(8'h10, 1, 1'b0, -1);
    check("s1_bank_vld_end", bank_vld, 2'b00);

    // Overlap: fill bank1, stream it x4 while bank0 loads.
    do_load(32'h200, 8'h20, KK, 1, 1'b0);
    check("ov_bank_vld", bank_vld, 2'b10);
    fork
      stream(8'h20, 4, 1'b0, -1);
      begin
        repeat (5) @(negedge clk);
        do_load(32'h300, 8'h30, KK, 0, 1'b1);
        check("ov_mid_stream", w_valid, 1);
        check("ov_both_vld", bank_vld, 2'b11);
      end
    join
    check("ov_after", bank_vld, 2'b01);
    stream(8'h30, 1, 1'b0, -1);
    check("ov_end", bank_vld, 2'b00);

    // Backpressure on bank1.
    do_load(32'h400, 8'h40, KK, 0, 1'b0);
    check("bp_bank_vld", bank_vld, 2'b10);
    stream(8'h40, 1, 1'b1, -1);
    check("bp_end", bank_vld, 2'b00);

    // Both banks full: third load ignored; empty banks: stream ignored.
    do_load(32'h500, 8'h50, KK, 0, 1'b0);
    do_load(32'h600, 8'h60, KK, 0, 1'b0);
    check("full_bank_vld", bank_vld, 2'b11);
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("full_no_req0", ldr_req, 0);
    @(negedge clk);
    check("full_no_req1", ldr_req, 0);
    stream(8'h50, 1, 1'b0, -1);
    stream(8'h60, 0, 1'b0, -1);
    check("drain_bank_vld", bank_vld, 2'b00);
    @(negedge clk);
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    check("empty_no_valid0", w_valid, 0);
    @(negedge clk);
    check("empty_no_valid1", w_valid, 0);

    // Short and long loads both error and leave bank0 empty.
    do_load(32'h700, 8'h70, 7, 0, 1'b0);
    check("short_bank_vld", bank_vld, 2'b00);
    do_load(32'h710, 8'h70, 11, 0, 1'b0);
    check("long_bank_vld", bank_vld, 2'b00);
    do_load(32'h720, 8'h80, KK, 0, 1'b0);
    check("retry_bank_vld", bank_vld, 2'b01);
    stream(8'h80, 1, 1'b0, -1);

    // Flush mid-stream at beat 4, then stray loader traffic is ignored.
    do_load(32'h800, 8'h90, KK, 0, 1'b0);
    check("fl_bank_vld", bank_vld, 2'b10);
    stream(8'h90, 2, 1'b0, 4);
    ldr_valid = 1'b1; ldr_done_sig = 1'b1; ldr_data = dval(8'hA0, 0);
    @(negedge clk);
    ldr_valid = 1'b0; ldr_done_sig = 1'b0;
    @(negedge clk);
    check("stray_done", load_done, 0);
    check("stray_err", load_err, 0);
    check("stray_vld", bank_vld, 2'b00);

    // Asynchronous reset while a second load is requesting.
    do_load(32'h900, 8'hB0, KK, 0, 1'b0);
    check("rs_bank_vld", bank_vld, 2'b01);
    @(negedge clk);
    load_start = 1'b1;
    base_addr  = 19'h0A00;
    @(negedge clk);
    load_start = 1'b0;
    check("rs_req_before", ldr_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rs_ldr_req", ldr_req, 0);
    check("rs_bank_vld0", bank_vld, 2'b00);
    check("rs_w_valid", w_valid, 0);
    check("rs_base", ldr_base_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean load and stream after recovery.
    do_load(32'h100, 8'hC0, KK, 2, 1'b0);
    check("fin_bank_vld", bank_vld, 2'b01);
    stream(8'hC0, 1, 1'b0, -1);
    check("fin_end", bank_vld, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
